// File: rtl/video_stream_gen.sv
// -----------------------------------------------------------------------------
// video_stream_gen
// Raster source for the vvalid/hvalid/din interface of the 3x3 line buffer.
// Generates frames with a programmable active area and programmable blanking.
// One of four test patterns fills the active pixels.
//
// Ports
//   clk        in   1   pixel clock
//   rst_b      in   1   asynchronous active-low reset
//   start      in   1   pulse: begin continuous frame generation (ignored when busy)
//   stop       in   1   pulse: finish the frame in flight, then go idle
//   pat_sel    in   2   0 h-ramp, 1 v-ramp, 2 checkerboard, 3 constant
//   pat_const  in   DW  pixel value used when pat_sel = 3
//   vvalid     out  1   frame valid
//   hvalid     out  1   line valid
//   dout       out  DW  pixel, qualified by hvalid (0 otherwise)
//   busy       out  1   high from start acceptance until back in IDLE
//   frame_cnt  out  16  completed-frame count, wraps
// -----------------------------------------------------------------------------
module video_stream_gen #(
    parameter int DW       = 8,
    parameter int H_ACTIVE = 1920,
    parameter int H_BLANK  = 128,
    parameter int V_ACTIVE = 1080,
    parameter int V_FRONT  = 2,
    parameter int V_BACK   = 2,
    parameter int V_GAP    = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    pat_sel,
    input  logic [DW-1:0] pat_const,
    output logic          vvalid,
    output logic          hvalid,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW      = $clog2(H_TOTAL);

    typedef logic [HW-1:0] hcnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VPRE,
        S_ACT,
        S_VPOST,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    hcnt_t         hcnt_q, hcnt_d;
    logic [15:0]   vcnt_q, vcnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]    pat_sel_q, pat_sel_d;
    logic [DW-1:0] pat_const_q, pat_const_d;
    logic          pat_load;
    logic          line_end;
    logic          seg_end;

    logic          vvalid_q, vvalid_d;
    logic          hvalid_q, hvalid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          busy_q, busy_d;

    // Index of the last line spent in each state.
    function automatic logic [15:0] last_line(input state_t s);
        case (s)
            S_VPRE:  return 16'(V_FRONT - 1);
            S_ACT:   return 16'(V_ACTIVE - 1);
            S_VPOST: return 16'(V_BACK - 1);
            default: return 16'(V_GAP - 1);
        endcase
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [1:0]    sel,
                                              input logic [DW-1:0] cval,
                                              input hcnt_t         x,
                                              input logic [15:0]   y);
        case (sel)
            2'd0:    return DW'(x);
            2'd1:    return DW'(y);
            2'd2:    return ((((32'(x) ^ 32'(y)) >> 3) & 32'd1) != 32'd0) ? {DW{1'b1}} : '0;
            default: return cval;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        stop_pend_d = stop_pend_q;
        frame_cnt_d = frame_cnt_q;
        pat_load    = 1'b0;
        line_end    = (hcnt_q == hcnt_t'(H_TOTAL - 1));
        seg_end     = line_end && (vcnt_q == last_line(state_q));

        if (state_q == S_IDLE) begin
            // A stop arriving together with start is dropped: stop_pend starts clear.
            if (start) begin
                state_d     = S_VPRE;
                hcnt_d      = '0;
                vcnt_d      = '0;
                stop_pend_d = 1'b0;
                pat_load    = 1'b1;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (stop) begin
                stop_pend_d = 1'b1;
            end
            if (line_end) begin
                vcnt_d = vcnt_q + 16'd1;
            end
            if (seg_end) begin
                vcnt_d = '0;
                case (state_q)
                    S_VPRE:  state_d = S_ACT;
                    S_ACT:   state_d = S_VPOST;
                    S_VPOST: begin
                        state_d     = S_GAP;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    default: begin
                        // A stop landing in the final gap cycle still ends generation.
                        if (stop_pend_q || stop) begin
                            state_d     = S_IDLE;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d  = S_VPRE;
                            pat_load = 1'b1;
                        end
                    end
                endcase
            end
        end

        pat_sel_d   = pat_load ? pat_sel   : pat_sel_q;
        pat_const_d = pat_load ? pat_const : pat_const_q;

        // Outputs are computed from next state so the registered copies line up.
        vvalid_d = (state_d == S_VPRE) || (state_d == S_ACT) || (state_d == S_VPOST);
        hvalid_d = (state_d == S_ACT) && (32'(hcnt_d) < 32'(H_ACTIVE));
        dout_d   = hvalid_d ? pattern(pat_sel_d, pat_const_d, hcnt_d, vcnt_d) : '0;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= '0;
            vvalid_q    <= 1'b0;
            hvalid_q    <= 1'b0;
            dout_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            stop_pend_q <= stop_pend_d;
            frame_cnt_q <= frame_cnt_d;
            vvalid_q    <= vvalid_d;
            hvalid_q    <= hvalid_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
        end
    end

    // Pattern selection is reloaded before use on every frame, so it needs no reset.
    always_ff @(posedge clk) begin
        pat_sel_q   <= pat_sel_d;
        pat_const_q <= pat_const_d;
    end

    assign vvalid    = vvalid_q;
    assign hvalid    = hvalid_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_video_stream_gen
// Scoreboard bench: the stimulus process advances a frame-position model each
// cycle and queues the expected outputs; a monitor on the falling edge pops
// and compares them against the DUT, and also checks vvalid/hvalid run lengths.
// -----------------------------------------------------------------------------
module tb_video_stream_gen;

    localparam int DW    = 8;
    localparam int HA    = 8;
    localparam int HB    = 8;
    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VB    = 1;
    localparam int VG    = 2;
    localparam int HT    = HA + HB;
    localparam int FRAME = (VF + VA + VB) * HT;
    localparam int PER   = (VF + VA + VB + VG) * HT;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          stop;
    logic [1:0]    pat_sel;
    logic [DW-1:0] pat_const;
    logic          vvalid;
    logic          hvalid;
    logic [DW-1:0] dout;
    logic          busy;
    logic [15:0]   frame_cnt;

    video_stream_gen #(
        .DW(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .V_FRONT(VF), .V_BACK(VB), .V_GAP(VG)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .stop(stop),
        .pat_sel(pat_sel), .pat_const(pat_const),
        .vvalid(vvalid), .hvalid(hvalid), .dout(dout),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          vv;
        logic          hv;
        logic [DW-1:0] d;
        logic          bz;
        logic [15:0]   fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: position inside a repeating frame period.
    int            m_active;
    int            m_pos;
    int            m_pend;
    logic [15:0]   m_fc;
    logic [1:0]    m_psel;
    logic [DW-1:0] m_pconst;

    function automatic void model_reset();
        m_active = 0;
        m_pos    = 0;
        m_pend   = 0;
        m_fc     = 16'd0;
    endfunction

    function automatic void model_step();
        if (!rst_b) begin
            model_reset();
            return;
        end
        if (m_active == 0) begin
            if (start) begin
                m_active = 1;
                m_pos    = 0;
                m_pend   = 0;
                m_psel   = pat_sel;
                m_pconst = pat_const;
            end
        end else begin
            if (stop) m_pend = 1;
            if (m_pos == PER - 1) begin
                m_pos = 0;
                if (m_pend != 0) begin
                    m_active = 0;
                    m_pend   = 0;
                end else begin
                    m_psel   = pat_sel;
                    m_pconst = pat_const;
                end
            end else begin
                m_pos++;
                if (m_pos == FRAME) m_fc = m_fc + 16'd1;
            end
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int   line, x, y;
        e    = '0;
        e.fc = m_fc;
        if (m_active != 0) begin
            line = m_pos / HT;
            x    = m_pos % HT;
            y    = line - VF;
            e.bz = 1'b1;
            e.vv = (m_pos < FRAME);
            e.hv = (line >= VF) && (line < VF + VA) && (x < HA);
            if (e.hv) begin
                case (m_psel)
                    2'd0:    e.d = DW'(x % 256);
                    2'd1:    e.d = DW'(y % 256);
                    2'd2:    e.d = ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 8'hFF : 8'h00;
                    default: e.d = m_pconst;
                endcase
            end
        end
        return e;
    endfunction

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic tick();
        if (!rst_b) model_reset();
        q.push_back(expect_now());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n, input bit rnd_pat, input bit rnd_start);
        for (int i = 0; i < n; i++) begin
            if (rnd_pat && $urandom_range(39) == 0) begin
                pat_sel   = 2'($urandom_range(3));
                pat_const = DW'($urandom);
            end
            if (rnd_start && $urandom_range(49) == 0) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic wait_hvalid();
        int n;
        n = 0;
        while (hvalid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        if (hvalid === 1'b1) n_pass++;
        else $display("FAIL wait_hvalid: hvalid=%b, required 1 within 300 cycles", hvalid);
    endtask

    // Monitor: compare every cycle and check burst lengths.
    int vrun = 0;
    int hrun = 0;
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            a = {vvalid, hvalid, dout, busy, frame_cnt};
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cyc);
            end else begin
                e = q.pop_front();
                if (a === e) n_pass++;
                else $display("FAIL outputs cycle %0d: got vv=%b hv=%b dout=%0d busy=%b fc=%0d, required vv=%b hv=%b dout=%0d busy=%b fc=%0d",
                              cyc, a.vv, a.hv, a.d, a.bz, a.fc, e.vv, e.hv, e.d, e.bz, e.fc);
            end
            if (vvalid === 1'b1) vrun++;
            else begin
                if (vrun != 0 && rst_b) begin
                    n_checks++;
                    if (vrun == FRAME) n_pass++;
                    else $display("FAIL vvalid_len cycle %0d: got %0d, required %0d", cyc, vrun, FRAME);
                end
                vrun = 0;
            end
            if (hvalid === 1'b1) hrun++;
            else begin
                if (hrun != 0 && rst_b) begin
                    n_checks++;
                    if (hrun == HA) n_pass++;
                    else $display("FAIL hvalid_len cycle %0d: got %0d, required %0d", cyc, hrun, HA);
                end
                hrun = 0;
            end
        end
    end

    initial begin
        model_reset();
        m_psel    = 2'd0;
        m_pconst  = '0;
        rst_b     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        pat_sel   = 2'd0;
        pat_const = '0;
        #2;
        // Reset held with start asserted: everything stays at zero.
        rst_b = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst_b = 1'b1;
        start = 1'b0;
        run(4, 1'b0, 1'b0);

        // Horizontal ramp frame, pattern change mid-frame lands on the next frame.
        pat_sel   = 2'd0;
        pat_const = 8'h5A;
        start     = 1'b1;
        tick();
        start = 1'b0;
        run(40, 1'b0, 1'b0);
        pat_sel = 2'd1;
        run(88 + PER, 1'b0, 1'b0);

        // Random pattern changes and ignored start pulses while running.
        run(4 * PER, 1'b1, 1'b1);

        // Stop during the active region: frame completes, then idle.
        wait_hvalid();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run(2 * PER + 40, 1'b0, 1'b0);

        // Start and stop in the same idle cycle: start wins.
        pat_sel   = 2'd3;
        pat_const = DW'($urandom);
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        run(3 * PER, 1'b1, 1'b1);

        // One-cycle reset in the active region, then stay idle.
        wait_hvalid();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        run(200, 1'b1, 1'b0);

        // Restart, stop at a random point, drain to idle.
        pat_sel = 2'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        run($urandom_range(50, 300), 1'b1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run(2 * PER + 20, 1'b0, 1'b0);

        if (!rst_b) model_reset();
        q.push_back(expect_now());
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
